// File: rtl/mux_pkg.sv
// Shared types and helpers for the scanning N-to-1 multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Output register occupancy; the encoding doubles as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_n_to_1_rr_pick.sv
// Rotating-priority finder: first enabled channel at or after ptr, wrapping modulo N.
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned SW = clog2(N)
) (
    input  logic [N-1:0]  ch_en,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] pick,
    output logic          found
);

    always_comb begin
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && ch_en[idx]) begin
                pick  = SW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_n_to_1.sv
// N-to-1 W-bit mux with manual/round-robin selection, registered output and valid/ready.
module mux_scan_n_to_1
    import mux_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 1,
    parameter int unsigned SW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] din,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    input  logic [N-1:0]   ch_en,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  out_ch,
    output logic           sel_err
);

    state_e        state_q, state_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          sel_err_q, sel_err_d;

    logic [SW-1:0] rr_pick_c;
    logic          rr_found_c;
    logic          sel_ok_c;
    logic          slot_c;
    logic [SW-1:0] pick_c;
    logic          pick_ok_c;
    logic [W-1:0]  pick_data_c;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .ch_en (ch_en),
        .ptr   (ptr_q),
        .pick  (rr_pick_c),
        .found (rr_found_c)
    );

    assign sel_ok_c = (32'(sel) < N);
    assign slot_c   = (state_q == ST_EMPTY) || out_ready;

    // Candidate channel for this cycle, from either selection source.
    always_comb begin
        pick_c    = sel;
        pick_ok_c = sel_ok_c;
        if (mode == MODE_SCAN) begin
            pick_c    = rr_pick_c;
            pick_ok_c = rr_found_c;
        end
    end

    always_comb begin
        pick_data_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (pick_c == SW'(k)) begin
                pick_data_c = din[k*W +: W];
            end
        end
    end

    // A held sample is only replaced on a slot cycle; stalls freeze everything.
    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        out_ch_d  = out_ch_q;
        ptr_d     = ptr_q;
        sel_err_d = 1'b0;
        if (slot_c) begin
            if (pick_ok_c) begin
                state_d  = ST_FULL;
                dout_d   = pick_data_c;
                out_ch_d = pick_c;
                if (mode == MODE_SCAN) begin
                    ptr_d = (pick_c == SW'(N - 1)) ? '0 : pick_c + SW'(1);
                end
            end else begin
                state_d = ST_EMPTY;
                if (mode == MODE_MANUAL) begin
                    sel_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            dout_q    <= '0;
            out_ch_q  <= '0;
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            out_ch_q  <= out_ch_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign dout      = dout_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n_to_1.sv
// Scoreboard bench for mux_scan_n_to_1: N=4 main instance plus an N=3 instance for sel >= N.
module tb_mux_scan_n_to_1;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned N3 = 3;

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] din;
    logic [SW-1:0]  sel;
    logic           mode;
    logic [N-1:0]   ch_en;
    logic           out_ready;
    logic           out_valid;
    logic [W-1:0]   dout;
    logic [SW-1:0]  out_ch;
    logic           sel_err;

    logic [N3*W-1:0] d3_din;
    logic [SW-1:0]   d3_sel;
    logic            d3_mode;
    logic [N3-1:0]   d3_ch_en;
    logic            d3_out_ready;
    logic            d3_out_valid;
    logic [W-1:0]    d3_dout;
    logic [SW-1:0]   d3_out_ch;
    logic            d3_sel_err;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
    } exp_t;

    exp_t exp_q[$];
    bit   m_valid;
    int   m_ptr;
    bit   m_selerr;

    mux_scan_n_to_1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .sel       (sel),
        .mode      (mode),
        .ch_en     (ch_en),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .out_ch    (out_ch),
        .sel_err   (sel_err)
    );

    mux_scan_n_to_1 #(.N(N3), .W(W)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (d3_din),
        .sel       (d3_sel),
        .mode      (d3_mode),
        .ch_en     (d3_ch_en),
        .out_ready (d3_out_ready),
        .out_valid (d3_out_valid),
        .dout      (d3_dout),
        .out_ch    (d3_out_ch),
        .sel_err   (d3_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: what the register should hold after each edge, by the selection rules.
    always @(posedge clk or negedge rst_n) begin
        int   pick;
        int   k;
        exp_t e;
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_ptr    = 0;
            m_selerr = 1'b0;
            exp_q.delete();
        end else begin
            m_selerr = 1'b0;
            if (!m_valid || out_ready) begin
                pick = -1;
                if (mode == 1'b0) begin
                    if (int'(sel) < int'(N)) pick = int'(sel);
                    else m_selerr = 1'b1;
                end else begin
                    for (int i = 0; i < int'(N); i++) begin
                        k = (m_ptr + i) % int'(N);
                        if (pick < 0 && ch_en[k]) pick = k;
                    end
                end
                if (pick >= 0) begin
                    e.data = din[pick*W +: W];
                    e.ch   = pick;
                    exp_q.push_back(e);
                    m_valid = 1'b1;
                    if (mode == 1'b1) m_ptr = (pick + 1) % int'(N);
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares the presented sample against the scoreboard head, pops on handoff.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("sel_err", 32'(sel_err), 32'(m_selerr));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 32'(1), 32'(0));
                end else begin
                    chk("sb_dout", 32'(dout), 32'(exp_q[0].data));
                    chk("sb_out_ch", 32'(out_ch), 32'(exp_q[0].ch));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] sweep_d [4];
        int           scan_ch [5];
        logic [W-1:0] scan_d  [5];

        sweep_d = '{4'hA, 4'hB, 4'hC, 4'hD};
        scan_ch = '{1, 3, 1, 3, 1};
        scan_d  = '{4'hB, 4'hD, 4'hB, 4'hD, 4'hB};
        n_cmp = 0;
        n_bad = 0;

        rst_n        = 1'b0;
        din          = 16'h1F3E;
        sel          = 2'd3;
        mode         = 1'b1;
        ch_en        = 4'b1111;
        out_ready    = 1'b1;
        d3_din       = 12'hCBA;
        d3_sel       = 2'd0;
        d3_mode      = 1'b0;
        d3_ch_en     = 3'b111;
        d3_out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_out_ch", 32'(out_ch), 32'(0));
        chk("rst_sel_err", 32'(sel_err), 32'(0));
        chk("rst3_out_valid", 32'(d3_out_valid), 32'(0));
        rst_n = 1'b1;

        // Manual sweep
        din  = 16'hDCBA;
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            tick();
            chk("sweep_dout", 32'(dout), 32'(sweep_d[s]));
            chk("sweep_out_ch", 32'(out_ch), 32'(s));
        end

        // Backpressure holds C while ch2 changes
        sel = 2'd2;
        tick();
        out_ready = 1'b0;
        din = 16'hD7BA;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("stall_dout", 32'(dout), 32'(4'hC));
            chk("stall_valid", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        tick();
        chk("after_stall_dout", 32'(dout), 32'(4'h7));
        din = 16'hDCBA;

        // Scan over mask 1010
        mode  = 1'b1;
        ch_en = 4'b1010;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("scan_out_ch", 32'(out_ch), 32'(scan_ch[s]));
            chk("scan_dout", 32'(dout), 32'(scan_d[s]));
        end

        // Empty mask drains the register and leaves ptr at 2
        ch_en = 4'b0000;
        tick();
        chk("empty_valid", 32'(out_valid), 32'(0));
        chk("empty_sel_err", 32'(sel_err), 32'(0));
        tick();
        chk("empty_valid2", 32'(out_valid), 32'(0));
        ch_en = 4'b1111;
        tick();
        chk("ptr_held_out_ch", 32'(out_ch), 32'(2));

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            din       = 16'($urandom);
            sel       = SW'($urandom);
            mode      = 1'($urandom);
            ch_en     = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // N=3: illegal select refuses the load, dout holds
        d3_sel = 2'd1;
        tick();
        chk("n3_valid", 32'(d3_out_valid), 32'(1));
        chk("n3_dout", 32'(d3_dout), 32'(4'hB));
        d3_sel = 2'd3;
        tick();
        chk("n3_sel_err", 32'(d3_sel_err), 32'(1));
        chk("n3_err_valid", 32'(d3_out_valid), 32'(0));
        chk("n3_err_dout_hold", 32'(d3_dout), 32'(4'hB));
        d3_sel       = 2'd0;
        d3_out_ready = 1'b0;
        tick();
        chk("n3_sel_err_pulse", 32'(d3_sel_err), 32'(0));
        chk("n3_load_a", 32'(d3_dout), 32'(4'hA));
        d3_sel = 2'd3;
        tick();
        chk("n3_stall_no_err", 32'(d3_sel_err), 32'(0));
        chk("n3_stall_valid", 32'(d3_out_valid), 32'(1));

        // Mid-stall asynchronous reset
        out_ready = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid3", 32'(d3_out_valid), 32'(0));
        chk("async_rst_valid", 32'(out_valid), 32'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
